test1_apb_sequencer: RTL and testbench
======================================

# test1_apb_sequencer

APB master sequencer that drives the TEST1 arithmetic peripheral (X/Y/Z registers, add/sub/mac triggers) on behalf of a single requester. It accepts one operation per valid/ready handshake, issues the four-access APB sequence (load X, load Y, trigger, read Z), and returns the result or an error on a valid/ready response channel. It sits between a core-side command source and the peripheral's APB slave port.

## Interface
- BW_ADDR, 32, APB address width
- BW_DATA, 32, APB data width; also operand/result width
- BASE_ADDR, 0, peripheral base address; all accesses are BASE_ADDR + offset, truncated to BW_ADDR
- TIMEOUT_CYCLES, 16, pready wait limit; used only with TEST1_SEQ_TIMEOUT_EN
- clk  in  1  clock
- rstnn  in  1  asynchronous active-low reset
- req_valid  in  1  operation request valid
- req_ready  out  1  sequencer can accept a request
- req_op  in  2  0=add, 1=sub, 2=mac, 3=reserved
- req_x, req_y, req_acc  in  BW_DATA each  operands; req_acc used by mac only
- rsp_valid  out  1  result valid
- rsp_ready  in  1  consumer accepts result
- rsp_data  out  BW_DATA  Z value read back (0 on error)
- rsp_err  out  1  operation failed
- spsel, spenable, spwrite  out  1 each  APB master controls
- spaddr  out  BW_ADDR  APB address
- spwdata  out  BW_DATA  APB write data
- sprdata  in  BW_DATA  APB read data
- spready, spslverr  in  1 each  APB completion and error

## Operation
- FSM states: IDLE, WR_X, WR_Y, TRIG, RD_Z, RESP; each access state has SETUP (spsel=1, spenable=0) and ACCESS (spsel=1, spenable=1) phases.
- IDLE: req_ready=1; on req_valid latch op and operands, go to WR_X SETUP. In op=3: no APB access, go directly to RESP with rsp_err=1, rsp_data=0.
- WR_X: write req_x to offset 0x0. WR_Y: write req_y to offset 0x4.
- TRIG: add = write 0 to 0xC; sub = read 0xC (data discarded); mac = write req_acc to 0x10.
- RD_Z: read 0x8; capture sprdata into rsp_data when spready=1.
- ACCESS holds until spready=1; then advance to the next state's SETUP (RD_Z advances to RESP).
- spslverr sampled only with spready=1 in ACCESS; if 1, abort remaining accesses, go to RESP with rsp_err=1, rsp_data=0.
- RESP: rsp_valid=1, outputs stable until rsp_ready=1; then IDLE. No request is accepted in the same cycle as the response handshake.
- spwrite, spaddr, spwdata held constant across SETUP and ACCESS of one access; spsel/spenable=0 in IDLE and RESP.

## Timing
- Reset values: req_ready=1 (combinational from IDLE), rsp_valid=0, rsp_data=0, rsp_err=0, spsel=0, spenable=0, spwrite=0, spaddr=0, spwdata=0.
- All APB and rsp outputs are registered.
- Zero-wait slave, accept at edge 0: access n (n=0..3) SETUP in cycle 2n+1, ACCESS in cycle 2n+2; rsp_valid in cycle 9. Each wait state adds one cycle.
- Back-to-back: next accept no earlier than cycle after rsp handshake.
- Reset asserted mid-sequence: immediate return to IDLE, all outputs to reset values; partial APB transfer abandoned, no response issued.

## Configuration
- TEST1_SEQ_TIMEOUT_EN defined: counter counts consecutive ACCESS cycles with spready=0; reaching TIMEOUT_CYCLES drops spsel/spenable next cycle and goes to RESP with rsp_err=1, rsp_data=0. Counter clears on each SETUP.
- Undefined: no counter; ACCESS waits indefinitely for spready.

## Structure
- Package test1_seq_pkg: register offsets (0x0, 0x4, 0x8, 0xC, 0x10), opcode encodings, FSM state encoding.
- Sub-module test1_apb_xfer: single-transfer engine (start, addr, write, wdata -> done, rdata, err, optional timeout); test1_apb_sequencer instantiates it once and sequences four transfers.

## Test plan
- add x=5, y=3, zero-wait slave model -> APB writes 0x0=5, 0x4=3, 0xC, read 0x8; rsp_data=8, rsp_err=0, rsp_valid in cycle 9.
- sub x=3, y=5 -> trigger is read of 0xC; rsp_data=0xFFFFFFFE.
- mac x=4, y=6, acc=10 with 2 wait states on every access -> write 0x10=10; rsp_data=34; rsp_valid in cycle 17; spaddr/spwdata stable through waits.
- spslverr=1 on WR_Y -> no TRIG/RD_Z access; rsp_err=1, rsp_data=0; op=3 -> no APB activity, rsp_err=1.
- rsp_ready held low 5 cycles -> rsp outputs stable, req_ready=0; with TEST1_SEQ_TIMEOUT_EN and spready stuck 0 -> rsp_err=1 after 16 ACCESS cycles.
- rstnn pulsed during TRIG ACCESS -> spsel=0, rsp_valid=0 immediately; next add x=1, y=1 returns 2.

Source files
------------

// File: rtl/test1_seq_pkg.sv
// Shared definitions for the TEST1 APB sequencer: register offsets, opcodes, FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package test1_seq_pkg;

  // Peripheral register map, relative to the sequencer's BASE_ADDR
  localparam logic [7:0] OFF_X    = 8'h00;
  localparam logic [7:0] OFF_Y    = 8'h04;
  localparam logic [7:0] OFF_Z    = 8'h08;
  localparam logic [7:0] OFF_TRIG = 8'h0C;  // write = add, read = sub
  localparam logic [7:0] OFF_MAC  = 8'h10;  // write acc = mac

  typedef enum logic [1:0] {
    OP_ADD  = 2'd0,
    OP_SUB  = 2'd1,
    OP_MAC  = 2'd2,
    OP_RSVD = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WR_X = 3'd1,
    ST_WR_Y = 3'd2,
    ST_TRIG = 3'd3,
    ST_RD_Z = 3'd4,
    ST_RESP = 3'd5
  } seq_state_e;

endpackage

// File: rtl/test1_apb_sequencer_if.sv
// Request/response channels plus APB master bus of the TEST1 sequencer.
// Latency: n/a (signal bundle only).
// Backpressure: req and rsp are valid/ready; APB completion is spready.
// Modports: master = sequencer side, slave = requester/consumer/peripheral side.
interface test1_apb_sequencer_if #(
  parameter int BW_ADDR = 32,
  parameter int BW_DATA = 32
);
  logic               req_valid;
  logic               req_ready;
  logic [1:0]         req_op;
  logic [BW_DATA-1:0] req_x;
  logic [BW_DATA-1:0] req_y;
  logic [BW_DATA-1:0] req_acc;

  logic               rsp_valid;
  logic               rsp_ready;
  logic [BW_DATA-1:0] rsp_data;
  logic               rsp_err;

  logic               spsel;
  logic               spenable;
  logic               spwrite;
  logic [BW_ADDR-1:0] spaddr;
  logic [BW_DATA-1:0] spwdata;
  logic [BW_DATA-1:0] sprdata;
  logic               spready;
  logic               spslverr;

  modport master (
    input  req_valid, req_op, req_x, req_y, req_acc, rsp_ready,
           sprdata, spready, spslverr,
    output req_ready, rsp_valid, rsp_data, rsp_err,
           spsel, spenable, spwrite, spaddr, spwdata
  );

  modport slave (
    output req_valid, req_op, req_x, req_y, req_acc, rsp_ready,
           sprdata, spready, spslverr,
    input  req_ready, rsp_valid, rsp_data, rsp_err,
           spsel, spenable, spwrite, spaddr, spwdata
  );
endinterface

// File: rtl/test1_apb_xfer.sv
// Single APB transfer engine: start -> SETUP -> ACCESS (held until pready) -> done/err.
// Latency: SETUP in the cycle after start, ACCESS the cycle after; done when pready in ACCESS.
// Backpressure: ACCESS waits on pready; with TEST1_SEQ_TIMEOUT_EN it gives up after TIMEOUT_CYCLES.
// Ports: start/addr/write/wdata in; done/err/rdata out (combinational, valid in the
// completing ACCESS cycle); psel/penable/pwrite/paddr/pwdata registered APB outputs.
module test1_apb_xfer #(
  parameter int BW_ADDR        = 32,
  parameter int BW_DATA        = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic               clk,
  input  logic               rstnn,
  input  logic               start,
  input  logic [BW_ADDR-1:0] addr,
  input  logic               write,
  input  logic [BW_DATA-1:0] wdata,
  output logic               done,
  output logic               err,
  output logic [BW_DATA-1:0] rdata,
  output logic               psel,
  output logic               penable,
  output logic               pwrite,
  output logic [BW_ADDR-1:0] paddr,
  output logic [BW_DATA-1:0] pwdata,
  input  logic [BW_DATA-1:0] prdata,
  input  logic               pready,
  input  logic               pslverr
);

  logic access_ph;
  logic timeout;

  assign access_ph = psel & penable;

`ifdef TEST1_SEQ_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] tmo_cnt;

  // Counts ACCESS cycles without pready; restarted by every new SETUP
  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn)                   tmo_cnt <= '0;
    else if (start)               tmo_cnt <= '0;
    else if (access_ph && !pready) tmo_cnt <= tmo_cnt + CW'(1);
  end

  assign timeout = access_ph & ~pready & (tmo_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
  logic [31:0] unused_tmo;
  assign unused_tmo = 32'(TIMEOUT_CYCLES);
  assign timeout    = 1'b0;
`endif

  assign done  = (access_ph & pready) | timeout;
  assign err   = (access_ph & pready & pslverr) | timeout;
  assign rdata = prdata;

  // A new start may coincide with the previous transfer's completion, giving
  // back-to-back SETUP without an idle cycle in between.
  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      psel    <= 1'b0;
      penable <= 1'b0;
      pwrite  <= 1'b0;
      paddr   <= '0;
      pwdata  <= '0;
    end else if (start) begin
      psel    <= 1'b1;
      penable <= 1'b0;
      pwrite  <= write;
      paddr   <= addr;
      pwdata  <= wdata;
    end else if (psel && !penable) begin
      penable <= 1'b1;
    end else if (done) begin
      psel    <= 1'b0;
      penable <= 1'b0;
    end
  end

endmodule

// File: rtl/test1_apb_sequencer.sv
// Runs one TEST1 operation per request: write X, write Y, trigger, read Z, then respond.
// Latency: zero-wait slave gives rsp_valid 9 cycles after accept; +1 per APB wait state.
// Backpressure: req_ready only in IDLE; response held until rsp_ready.
// Ports: clk, rstnn (async active-low), bus (test1_apb_sequencer_if.master).
// Optional TEST1_SEQ_TIMEOUT_EN: abort with rsp_err when pready stays low TIMEOUT_CYCLES.
module test1_apb_sequencer
  import test1_seq_pkg::*;
#(
  parameter int                 BW_ADDR        = 32,
  parameter int                 BW_DATA        = 32,
  parameter logic [BW_ADDR-1:0] BASE_ADDR      = '0,
  parameter int                 TIMEOUT_CYCLES = 16
) (
  input logic                      clk,
  input logic                      rstnn,
  test1_apb_sequencer_if.master    bus
);

  seq_state_e         state, state_nxt;
  op_e                op_q;
  logic [BW_DATA-1:0] y_q, acc_q;

  logic               req_take;
  logic               x_start, x_write, x_done, x_err;
  logic [BW_ADDR-1:0] x_addr;
  logic [BW_DATA-1:0] x_wdata, x_rdata;

  logic               rsp_load, rsp_err_nxt;
  logic [BW_DATA-1:0] rsp_data_nxt;

  assign bus.req_ready = (state == ST_IDLE);

  // Next access is issued combinationally so its SETUP lands in the cycle
  // right after the accept / previous completion.
  always_comb begin
    state_nxt    = state;
    req_take     = 1'b0;
    x_start      = 1'b0;
    x_addr       = BASE_ADDR;
    x_write      = 1'b0;
    x_wdata      = '0;
    rsp_load     = 1'b0;
    rsp_err_nxt  = 1'b0;
    rsp_data_nxt = '0;
    unique case (state)
      ST_IDLE: begin
        if (bus.req_valid) begin
          req_take = 1'b1;
          if (op_e'(bus.req_op) == OP_RSVD) begin
            state_nxt   = ST_RESP;
            rsp_load    = 1'b1;
            rsp_err_nxt = 1'b1;
          end else begin
            state_nxt = ST_WR_X;
            x_start   = 1'b1;
            x_addr    = BASE_ADDR + BW_ADDR'(OFF_X);
            x_write   = 1'b1;
            x_wdata   = bus.req_x;
          end
        end
      end
      ST_WR_X, ST_WR_Y, ST_TRIG, ST_RD_Z: begin
        if (x_err) begin
          // slave error (or timeout) abandons the remaining accesses
          state_nxt   = ST_RESP;
          rsp_load    = 1'b1;
          rsp_err_nxt = 1'b1;
        end else if (x_done) begin
          unique case (state)
            ST_WR_X: begin
              state_nxt = ST_WR_Y;
              x_start   = 1'b1;
              x_addr    = BASE_ADDR + BW_ADDR'(OFF_Y);
              x_write   = 1'b1;
              x_wdata   = y_q;
            end
            ST_WR_Y: begin
              state_nxt = ST_TRIG;
              x_start   = 1'b1;
              unique case (op_q)
                OP_SUB: x_addr = BASE_ADDR + BW_ADDR'(OFF_TRIG);
                OP_MAC: begin
                  x_addr  = BASE_ADDR + BW_ADDR'(OFF_MAC);
                  x_write = 1'b1;
                  x_wdata = acc_q;
                end
                default: begin
                  x_addr  = BASE_ADDR + BW_ADDR'(OFF_TRIG);
                  x_write = 1'b1;
                end
              endcase
            end
            ST_TRIG: begin
              state_nxt = ST_RD_Z;
              x_start   = 1'b1;
              x_addr    = BASE_ADDR + BW_ADDR'(OFF_Z);
            end
            default: begin
              state_nxt    = ST_RESP;
              rsp_load     = 1'b1;
              rsp_data_nxt = x_rdata;
            end
          endcase
        end
      end
      ST_RESP: if (bus.rsp_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // X goes straight into the first access; only Y and acc are needed later
  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      op_q  <= OP_ADD;
      y_q   <= '0;
      acc_q <= '0;
    end else if (req_take) begin
      op_q  <= op_e'(bus.req_op);
      y_q   <= bus.req_y;
      acc_q <= bus.req_acc;
    end
  end

  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      bus.rsp_valid <= 1'b0;
      bus.rsp_data  <= '0;
      bus.rsp_err   <= 1'b0;
    end else if (rsp_load) begin
      bus.rsp_valid <= 1'b1;
      bus.rsp_data  <= rsp_data_nxt;
      bus.rsp_err   <= rsp_err_nxt;
    end else if (state == ST_RESP && bus.rsp_ready) begin
      bus.rsp_valid <= 1'b0;
    end
  end

  test1_apb_xfer #(
    .BW_ADDR        (BW_ADDR),
    .BW_DATA        (BW_DATA),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_xfer (
    .clk     (clk),
    .rstnn   (rstnn),
    .start   (x_start),
    .addr    (x_addr),
    .write   (x_write),
    .wdata   (x_wdata),
    .done    (x_done),
    .err     (x_err),
    .rdata   (x_rdata),
    .psel    (bus.spsel),
    .penable (bus.spenable),
    .pwrite  (bus.spwrite),
    .paddr   (bus.spaddr),
    .pwdata  (bus.spwdata),
    .prdata  (bus.sprdata),
    .pready  (bus.spready),
    .pslverr (bus.spslverr)
  );

endmodule

// File: tb/tb_test1_apb_sequencer.sv
// Bench for test1_apb_sequencer: TEST1 peripheral model on the APB side, directed
// and random operations, expected results and access lists from plain arithmetic.
module tb_test1_apb_sequencer;

  localparam int TMO = 16;

  logic clk;
  logic rstnn;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  test1_apb_sequencer_if #(.BW_ADDR(32), .BW_DATA(32)) bus ();

  test1_apb_sequencer #(
    .BW_ADDR(32), .BW_DATA(32), .BASE_ADDR(32'h0), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk   (clk),
    .rstnn (rstnn),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- peripheral model + access log ----------------
  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
  } acc_t;

  acc_t        log_q[$];
  acc_t        cur;
  int          waited;
  int          s_wait   = 0;
  int          s_err_at = -1;
  bit          s_stuck  = 1'b0;
  logic [31:0] m_x, m_y, m_z;

  always @(negedge clk) begin
    if (!rstnn) begin
      bus.spready  = 1'b0;
      bus.spslverr = 1'b0;
      bus.sprdata  = '0;
    end else if (bus.spsel && !bus.spenable) begin
      cur.addr  = bus.spaddr;
      cur.wr    = bus.spwrite;
      cur.wdata = bus.spwdata;
      log_q.push_back(cur);
      waited       = 0;
      bus.spready  = 1'b0;
      bus.spslverr = 1'b0;
    end else if (bus.spsel && bus.spenable) begin
      chk("apb_hold_addr", bus.spaddr, cur.addr);
      chk("apb_hold_write", bus.spwrite, cur.wr);
      chk("apb_hold_wdata", bus.spwdata, cur.wdata);
      if (!s_stuck && waited >= s_wait) begin
        bus.spready  = 1'b1;
        bus.spslverr = ((log_q.size() - 1) == s_err_at);
        bus.sprdata  = $urandom;
        if (!bus.spslverr) begin
          if (cur.wr) begin
            case (cur.addr)
              32'h00:  m_x = cur.wdata;
              32'h04:  m_y = cur.wdata;
              32'h0C:  m_z = m_x + m_y;
              32'h10:  m_z = m_x * m_y + cur.wdata;
              default: ;
            endcase
          end else begin
            if (cur.addr == 32'h0C) m_z = m_x - m_y;
            if (cur.addr == 32'h08) bus.sprdata = m_z;
          end
        end
      end else begin
        waited++;
        bus.spready  = 1'b0;
        bus.spslverr = 1'b0;
      end
    end else begin
      bus.spready  = 1'b0;
      bus.spslverr = 1'b0;
    end
  end

  // ---------------- reference ----------------
  function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] x,
                                             input logic [31:0] y, input logic [31:0] acc);
    case (op)
      2'd0:    return x + y;
      2'd1:    return x - y;
      2'd2:    return x * y + acc;
      default: return 32'h0;
    endcase
  endfunction

  task automatic run_op(input logic [1:0] op, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] acc, input int waits, input int err_at,
                        input int hold, input bit stuck);
    acc_t        exp_q[$];
    acc_t        e;
    int          n_exp, exp_lat, c1;
    bit          found, exp_err;
    logic [31:0] exp_data;

    s_wait   = waits;
    s_err_at = err_at;
    s_stuck  = stuck;
    log_q.delete();

    e.addr = 32'h0; e.wr = 1'b1; e.wdata = x;   exp_q.push_back(e);
    e.addr = 32'h4; e.wr = 1'b1; e.wdata = y;   exp_q.push_back(e);
    if (op == 2'd1)      begin e.addr = 32'hC;  e.wr = 1'b0; e.wdata = 0;   end
    else if (op == 2'd2) begin e.addr = 32'h10; e.wr = 1'b1; e.wdata = acc; end
    else                 begin e.addr = 32'hC;  e.wr = 1'b1; e.wdata = 0;   end
    exp_q.push_back(e);
    e.addr = 32'h8; e.wr = 1'b0; e.wdata = 0;   exp_q.push_back(e);

    if (op == 2'd3) begin
      n_exp = 0; exp_err = 1'b1; exp_lat = 1;
    end else if (stuck) begin
      n_exp = 1; exp_err = 1'b1; exp_lat = 2 + TMO;
    end else if (err_at >= 0 && err_at < 4) begin
      n_exp = err_at + 1; exp_err = 1'b1; exp_lat = 1 + n_exp * (2 + waits);
    end else begin
      n_exp = 4; exp_err = 1'b0; exp_lat = 1 + 4 * (2 + waits);
    end
    exp_data = exp_err ? 32'h0 : ref_result(op, x, y, acc);

    @(negedge clk);
    bus.req_op    = op;
    bus.req_x     = x;
    bus.req_y     = y;
    bus.req_acc   = acc;
    bus.req_valid = 1'b1;
    chk("req_ready_idle", bus.req_ready, 1'b1);
    @(negedge clk);
    c1 = cyc;
    bus.req_valid = 1'b0;
    chk("req_ready_busy", bus.req_ready, 1'b0);

    found = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (bus.rsp_valid) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!found) begin
      chk("rsp_wait_expired", 1'b0, 1'b1);
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      bus.rsp_ready = 1'b0;
      return;
    end

    chk("rsp_latency", cyc - c1 + 1, exp_lat);
    chk("rsp_err", bus.rsp_err, exp_err);
    chk("rsp_data", bus.rsp_data, exp_data);
    chk("apb_access_count", log_q.size(), n_exp);
    for (int i = 0; i < n_exp && i < log_q.size(); i++) begin
      chk("apb_addr", log_q[i].addr, exp_q[i].addr);
      chk("apb_write", log_q[i].wr, exp_q[i].wr);
      if (exp_q[i].wr) chk("apb_wdata", log_q[i].wdata, exp_q[i].wdata);
    end

    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_rsp_valid", bus.rsp_valid, 1'b1);
      chk("hold_rsp_data", bus.rsp_data, exp_data);
      chk("hold_rsp_err", bus.rsp_err, exp_err);
      chk("hold_req_ready", bus.req_ready, 1'b0);
      chk("hold_spsel", bus.spsel, 1'b0);
    end

    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    chk("rsp_valid_drop", bus.rsp_valid, 1'b0);
    chk("req_ready_back", bus.req_ready, 1'b1);
  endtask

  // ---------------- main ----------------
  initial begin
    bit found;
    int err_at;

    rstnn         = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_op    = '0;
    bus.req_x     = '0;
    bus.req_y     = '0;
    bus.req_acc   = '0;
    bus.rsp_ready = 1'b0;
    #3;
    chk("rst_req_ready", bus.req_ready, 1'b1);
    chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
    chk("rst_rsp_data", bus.rsp_data, 32'h0);
    chk("rst_rsp_err", bus.rsp_err, 1'b0);
    chk("rst_spsel", bus.spsel, 1'b0);
    chk("rst_spenable", bus.spenable, 1'b0);
    chk("rst_spwrite", bus.spwrite, 1'b0);
    chk("rst_spaddr", bus.spaddr, 32'h0);
    chk("rst_spwdata", bus.spwdata, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rstnn = 1'b1;

    // op, x, y, acc, waits, err_at, hold, stuck
    run_op(2'd0, 32'd5, 32'd3, 32'd0, 0, -1, 0, 1'b0);   // add -> 8
    run_op(2'd1, 32'd3, 32'd5, 32'd0, 0, -1, 0, 1'b0);   // sub -> FFFFFFFE
    run_op(2'd2, 32'd4, 32'd6, 32'd10, 2, -1, 0, 1'b0);  // mac -> 34, 2 waits
    run_op(2'd0, 32'd7, 32'd9, 32'd0, 0, 1, 0, 1'b0);    // slave error on WR_Y
    run_op(2'd3, 32'd1, 32'd2, 32'd3, 0, -1, 0, 1'b0);   // reserved op
    run_op(2'd0, 32'd11, 32'd22, 32'd0, 1, -1, 5, 1'b0); // rsp_ready held low

    // reset during the trigger ACCESS phase
    s_wait = 2; s_err_at = -1; s_stuck = 1'b0;
    log_q.delete();
    @(negedge clk);
    bus.req_op = 2'd0; bus.req_x = 32'd9; bus.req_y = 32'd9; bus.req_valid = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (log_q.size() == 3 && bus.spsel && bus.spenable) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("rst_mid_reached_trig", found, 1'b1);
    #1 rstnn = 1'b0;
    #1;
    chk("rst_mid_spsel", bus.spsel, 1'b0);
    chk("rst_mid_spenable", bus.spenable, 1'b0);
    chk("rst_mid_rsp_valid", bus.rsp_valid, 1'b0);
    chk("rst_mid_req_ready", bus.req_ready, 1'b1);
    chk("rst_mid_spaddr", bus.spaddr, 32'h0);
    @(negedge clk);
    rstnn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_rsp_valid", bus.rsp_valid, 1'b0);
      chk("post_rst_spsel", bus.spsel, 1'b0);
    end
    run_op(2'd0, 32'd1, 32'd1, 32'd0, 0, -1, 0, 1'b0);   // -> 2

`ifdef TEST1_SEQ_TIMEOUT_EN
    run_op(2'd0, 32'd1, 32'd2, 32'd0, 0, -1, 0, 1'b1);   // spready stuck low
    s_stuck = 1'b0;
`endif

    for (int i = 0; i < 25; i++) begin
      err_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1;
      run_op(2'($urandom_range(0, 3)), $urandom, $urandom, $urandom,
             int'($urandom_range(0, 2)), err_at, int'($urandom_range(0, 3)), 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
